// File: rtl/raster_scan_ctrl.sv
// ============================================================================
// Module      : raster_scan_ctrl
// Description : Latches one triangle, walks its screen-clamped bounding box in
//               row-major order and streams covered pixels on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_scan_ctrl #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  in_v0_x,
    input  logic [9:0]  in_v1_x,
    input  logic [9:0]  in_v2_x,
    input  logic [8:0]  in_v0_y,
    input  logic [8:0]  in_v1_y,
    input  logic [8:0]  in_v2_y,
    output logic [9:0]  v0_x,
    output logic [9:0]  v1_x,
    output logic [9:0]  v2_x,
    output logic [8:0]  v0_y,
    output logic [8:0]  v1_y,
    output logic [8:0]  v2_y,
    output logic [9:0]  pixel_col,
    output logic [8:0]  pixel_row,
    input  logic        rasterize,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  out_col,
    output logic [8:0]  out_row,
    output logic        busy,
    output logic        done,
    output logic [18:0] hit_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BBOX = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [9:0] c_COL_LIM = 10'(H_RES - 1);
    localparam logic [8:0] c_ROW_LIM = 9'(V_RES - 1);

    function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [9:0] max10(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [8:0] max9(input logic [8:0] a, input logic [8:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [1:0]  r_state, w_state_nxt;
    logic [9:0]  r_v0_x, r_v1_x, r_v2_x;
    logic [8:0]  r_v0_y, r_v1_y, r_v2_y;
    logic [9:0]  r_col, r_xmin, r_xmax;
    logic [8:0]  r_row, r_ymax;
    logic        r_out_valid, r_busy, r_done;
    logic [9:0]  r_out_col;
    logic [8:0]  r_out_row;
    logic [18:0] r_hit_count;

    logic [9:0]  w_v0_x, w_v1_x, w_v2_x;
    logic [8:0]  w_v0_y, w_v1_y, w_v2_y;
    logic [9:0]  w_col, w_xmin_r, w_xmax_r;
    logic [8:0]  w_row, w_ymax_r;
    logic        w_out_valid, w_busy, w_done;
    logic [9:0]  w_out_col;
    logic [8:0]  w_out_row;
    logic [18:0] w_hit_count;

    logic [9:0]  w_bb_xmin, w_bb_xmax;
    logic [8:0]  w_bb_ymin, w_bb_ymax;
    logic        w_stall, w_last;

    // Clamping each extreme keeps the scan inside the screen even when the
    // whole triangle lies off to the right or bottom.
    assign w_bb_xmin = min10(min10(min10(r_v0_x, r_v1_x), r_v2_x), c_COL_LIM);
    assign w_bb_xmax = min10(max10(max10(r_v0_x, r_v1_x), r_v2_x), c_COL_LIM);
    assign w_bb_ymin = min9(min9(min9(r_v0_y, r_v1_y), r_v2_y), c_ROW_LIM);
    assign w_bb_ymax = min9(max9(max9(r_v0_y, r_v1_y), r_v2_y), c_ROW_LIM);

    assign w_stall = rasterize & r_out_valid & ~out_ready;
    assign w_last  = (r_col == r_xmax) && (r_row == r_ymax);

    always_ff @(posedge clk) begin : p_state_reg
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_state_nxt = S_BBOX;
                S_BBOX: w_state_nxt = S_SCAN;
                S_SCAN: if (!w_stall && w_last) w_state_nxt = S_DONE;
                S_DONE: if (!r_out_valid) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin : p_outputs
        w_v0_x      = r_v0_x;
        w_v1_x      = r_v1_x;
        w_v2_x      = r_v2_x;
        w_v0_y      = r_v0_y;
        w_v1_y      = r_v1_y;
        w_v2_y      = r_v2_y;
        w_col       = r_col;
        w_row       = r_row;
        w_xmin_r    = r_xmin;
        w_xmax_r    = r_xmax;
        w_ymax_r    = r_ymax;
        w_out_valid = r_out_valid;
        w_out_col   = r_out_col;
        w_out_row   = r_out_row;
        w_hit_count = r_hit_count;

        if (abort && (r_state != S_IDLE)) begin
            w_out_valid = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_v0_x      = in_v0_x;
                        w_v1_x      = in_v1_x;
                        w_v2_x      = in_v2_x;
                        w_v0_y      = in_v0_y;
                        w_v1_y      = in_v1_y;
                        w_v2_y      = in_v2_y;
                        w_hit_count = '0;
                    end
                end
                S_BBOX: begin
                    w_xmin_r = w_bb_xmin;
                    w_xmax_r = w_bb_xmax;
                    w_ymax_r = w_bb_ymax;
                    w_col    = w_bb_xmin;
                    w_row    = w_bb_ymin;
                end
                S_SCAN: begin
                    // A stall freezes the pixel so the core re-evaluates it.
                    if (!w_stall) begin
                        if (rasterize) begin
                            w_out_col   = r_col;
                            w_out_row   = r_row;
                            w_out_valid = 1'b1;
                            w_hit_count = r_hit_count + 19'd1;
                        end else if (out_ready) begin
                            w_out_valid = 1'b0;
                        end
                        if (!w_last) begin
                            if (r_col == r_xmax) begin
                                w_col = r_xmin;
                                w_row = r_row + 9'd1;
                            end else begin
                                w_col = r_col + 10'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) w_out_valid = 1'b0;
                end
                default: begin
                    w_out_valid = 1'b0;
                end
            endcase
        end

        w_busy = (w_state_nxt != S_IDLE);
        w_done = (w_state_nxt == S_DONE) && !w_out_valid;
    end

    always_ff @(posedge clk) begin : p_data_reg
        if (rst) begin
            r_v0_x      <= '0;
            r_v1_x      <= '0;
            r_v2_x      <= '0;
            r_v0_y      <= '0;
            r_v1_y      <= '0;
            r_v2_y      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_ymax      <= '0;
            r_out_valid <= 1'b0;
            r_out_col   <= '0;
            r_out_row   <= '0;
            r_hit_count <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_v0_x      <= w_v0_x;
            r_v1_x      <= w_v1_x;
            r_v2_x      <= w_v2_x;
            r_v0_y      <= w_v0_y;
            r_v1_y      <= w_v1_y;
            r_v2_y      <= w_v2_y;
            r_col       <= w_col;
            r_row       <= w_row;
            r_xmin      <= w_xmin_r;
            r_xmax      <= w_xmax_r;
            r_ymax      <= w_ymax_r;
            r_out_valid <= w_out_valid;
            r_out_col   <= w_out_col;
            r_out_row   <= w_out_row;
            r_hit_count <= w_hit_count;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    assign v0_x      = r_v0_x;
    assign v1_x      = r_v1_x;
    assign v2_x      = r_v2_x;
    assign v0_y      = r_v0_y;
    assign v1_y      = r_v1_y;
    assign v2_y      = r_v2_y;
    assign pixel_col = r_col;
    assign pixel_row = r_row;
    assign out_valid = r_out_valid;
    assign out_col   = r_out_col;
    assign out_row   = r_out_row;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hit_count = r_hit_count;

endmodule

`default_nettype wire

// File: tb/tb_raster_scan_ctrl.sv
// ============================================================================
// Module      : tb_raster_scan_ctrl
// Description : Self-checking bench for raster_scan_ctrl with a bench-side
//               inside-test core and a bounding-box/hit-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_raster_scan_ctrl;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready;
    logic [9:0]  in_v0_x, in_v1_x, in_v2_x;
    logic [8:0]  in_v0_y, in_v1_y, in_v2_y;
    logic [9:0]  v0_x, v1_x, v2_x, pixel_col, out_col;
    logic [8:0]  v0_y, v1_y, v2_y, pixel_row, out_row;
    logic        rasterize, out_valid, busy, done;
    logic [18:0] hit_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int v0x, v0y, v1x, v1y, v2x, v2y;
        int col0, row0;
        int hits;
        int done_off;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    // Inclusive edge-function test, either winding; collinear points count.
    function automatic logic inside_tri(input int px, input int py,
                                        input int ax, input int ay,
                                        input int bx, input int by,
                                        input int cx, input int cy);
        int e0, e1, e2;
        e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
        e1 = (cx - bx) * (py - by) - (cy - by) * (px - bx);
        e2 = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
        return ((e0 >= 0) && (e1 >= 0) && (e2 >= 0)) ||
               ((e0 <= 0) && (e1 <= 0) && (e2 <= 0));
    endfunction

    assign rasterize = inside_tri(int'(pixel_col), int'(pixel_row),
                                  int'(v0_x), int'(v0_y), int'(v1_x), int'(v1_y),
                                  int'(v2_x), int'(v2_y));

    raster_scan_ctrl #(.H_RES(H_RES), .V_RES(V_RES)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_v0_x(in_v0_x), .in_v1_x(in_v1_x), .in_v2_x(in_v2_x),
        .in_v0_y(in_v0_y), .in_v1_y(in_v1_y), .in_v2_y(in_v2_y),
        .v0_x(v0_x), .v1_x(v1_x), .v2_x(v2_x),
        .v0_y(v0_y), .v1_y(v1_y), .v2_y(v2_y),
        .pixel_col(pixel_col), .pixel_row(pixel_row), .rasterize(rasterize),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_row(out_row),
        .busy(busy), .done(done), .hit_count(hit_count)
    );

    function automatic int enc(input int c, input int r);
        return c * 1024 + r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic all_outputs_nonzero();
        return |{v0_x, v1_x, v2_x, v0_y, v1_y, v2_y, pixel_col, pixel_row,
                 out_valid, out_col, out_row, busy, done, hit_count};
    endfunction

    task automatic start_tri(input vec_t tv);
        @(negedge clk);
        in_v0_x = 10'(tv.v0x); in_v0_y = 9'(tv.v0y);
        in_v1_x = 10'(tv.v1x); in_v1_y = 9'(tv.v1y);
        in_v2_x = 10'(tv.v2x); in_v2_y = 9'(tv.v2y);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready low 5 cycles after first valid;
    // mode 2: random ready. chk_tbl selects the hand-computed table checks.
    task automatic run_scan(input vec_t tv, input int mode, input bit chk_tbl);
        int pq[$];
        int hq[$];
        int xs[3], ys[3];
        int xmin, xmax, ymin, ymax, model_hits;
        int k, done_k, hold_left;
        bit bp_started, frozen_prev, stab_pend;
        int stab_val;
        longint snap;

        xs[0] = tv.v0x; xs[1] = tv.v1x; xs[2] = tv.v2x;
        ys[0] = tv.v0y; ys[1] = tv.v1y; ys[2] = tv.v2y;
        xmin = xs[0]; xmax = xs[0]; ymin = ys[0]; ymax = ys[0];
        for (int i = 1; i < 3; i++) begin
            if (xs[i] < xmin) xmin = xs[i];
            if (xs[i] > xmax) xmax = xs[i];
            if (ys[i] < ymin) ymin = ys[i];
            if (ys[i] > ymax) ymax = ys[i];
        end
        if (xmin > H_RES - 1) xmin = H_RES - 1;
        if (xmax > H_RES - 1) xmax = H_RES - 1;
        if (ymin > V_RES - 1) ymin = V_RES - 1;
        if (ymax > V_RES - 1) ymax = V_RES - 1;
        for (int r = ymin; r <= ymax; r++)
            for (int c = xmin; c <= xmax; c++) begin
                pq.push_back(enc(c, r));
                if (inside_tri(c, r, tv.v0x, tv.v0y, tv.v1x, tv.v1y, tv.v2x, tv.v2y))
                    hq.push_back(enc(c, r));
            end
        model_hits = hq.size();

        @(negedge clk);
        in_v0_x = 10'(tv.v0x); in_v0_y = 9'(tv.v0y);
        in_v1_x = 10'(tv.v1x); in_v1_y = 9'(tv.v1y);
        in_v2_x = 10'(tv.v2x); in_v2_y = 9'(tv.v2y);
        start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        k = 0; done_k = -1; hold_left = 0;
        bp_started = 0; frozen_prev = 0; stab_pend = 0; stab_val = 0; snap = 0;

        while (done_k < 0 && k < 4000) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (k == 1) chk("busy_rise", busy, 1);
            if (chk_tbl && k == 2) chk("first_pixel", enc(pixel_col, pixel_row), enc(tv.col0, tv.row0));
            if (mode == 0 && k >= 2 && k - 2 < pq.size())
                chk("pixel_trace", enc(pixel_col, pixel_row), pq[k-2]);
            if (stab_pend)
                chk("out_hold", out_valid ? enc(out_col, out_row) : -1, stab_val);
            if (frozen_prev)
                chk("bp_frozen", {pixel_col, pixel_row, out_col, out_row, hit_count}, snap);
            if (done) done_k = k;

            frozen_prev = 0;
            if (mode == 0) begin
                out_ready = 1'b1;
            end else if (mode == 1) begin
                if (!bp_started && out_valid) begin
                    bp_started = 1;
                    hold_left = 5;
                    snap = {pixel_col, pixel_row, out_col, out_row, hit_count};
                end
                if (hold_left > 0) begin
                    out_ready = 1'b0;
                    hold_left--;
                    frozen_prev = 1;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end

            if (out_valid && out_ready) begin
                if (hq.size() == 0) chk("extra_hit", enc(out_col, out_row), -1);
                else chk("hit_stream", enc(out_col, out_row), hq.pop_front());
            end
            stab_pend = out_valid && !out_ready;
            stab_val  = enc(out_col, out_row);
        end

        if (done_k < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, required a done pulse", k);
        end else if (chk_tbl) begin
            chk("done_time", done_k, tv.done_off + ((mode == 1) ? 5 : 0));
        end
        chk("hit_count", hit_count, chk_tbl ? tv.hits : model_hits);
        chk("hits_left", hq.size(), 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_done_idle", {busy, done}, 0);
    endtask

    initial begin
        vec_t rv;
        int ox, oy, done_seen;

        tbl[0] = '{v0x:10,  v0y:10,  v1x:13,  v1y:10,  v2x:10,  v2y:13,  col0:10,  row0:10,  hits:10,  done_off:18};
        tbl[1] = '{v0x:10,  v0y:10,  v1x:10,  v1y:13,  v2x:13,  v2y:10,  col0:10,  row0:10,  hits:10,  done_off:18};
        tbl[2] = '{v0x:5,   v0y:5,   v1x:5,   v1y:5,   v2x:5,   v2y:5,   col0:5,   row0:5,   hits:1,   done_off:4};
        tbl[3] = '{v0x:630, v0y:470, v1x:700, v1y:470, v2x:630, v2y:500, col0:630, row0:470, hits:100, done_off:103};
        tbl[4] = '{v0x:700, v0y:500, v1x:800, v1y:500, v2x:700, v2y:510, col0:639, row0:479, hits:0,   done_off:3};
        tbl[5] = '{v0x:2,   v0y:3,   v1x:6,   v1y:3,   v2x:4,   v2y:3,   col0:2,   row0:3,   hits:5,   done_off:8};

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        in_v0_x = '0; in_v1_x = '0; in_v2_x = '0;
        in_v0_y = '0; in_v1_y = '0; in_v2_y = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", all_outputs_nonzero(), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_scan(tbl[i], 0, 1);

        run_scan(tbl[0], 1, 1);

        // Reset in the middle of a scan.
        start_tri(tbl[0]);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_mid_scan", all_outputs_nonzero(), 0);
        run_scan(tbl[0], 0, 1);

        // start during SCAN is dropped, then abort.
        start_tri(tbl[0]);
        repeat (3) @(negedge clk);
        in_v0_x = 10'd200; in_v0_y = 9'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_x", v0_x, 10);
        chk("start_ignored_y", v0_y, 10);
        chk("busy_in_scan", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        done_seen = 0;
        repeat (30) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        chk("abort_no_done", done_seen, 0);
        run_scan(tbl[5], 0, 1);

        for (int n = 0; n < 25; n++) begin
            ox = $urandom_range(0, 650);
            oy = $urandom_range(0, 490);
            rv.v0x = ox + $urandom_range(0, 12); rv.v0y = oy + $urandom_range(0, 12);
            rv.v1x = ox + $urandom_range(0, 12); rv.v1y = oy + $urandom_range(0, 12);
            rv.v2x = ox + $urandom_range(0, 12); rv.v2y = oy + $urandom_range(0, 12);
            rv.col0 = 0; rv.row0 = 0; rv.hits = 0; rv.done_off = 0;
            run_scan(rv, 2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
